// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding req/gnt/rvalid transaction, PC tracking, response FIFO.
// Optional performance counters are enabled by defining IF_FETCH_CTRL_PERF_EN.
module if_fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        capture_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic [1:0]  fsm_state_o
`ifdef IF_FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [15:0] perf_discard_o
`endif
);

    localparam logic [31:0] BOOT_WORD = {BOOT_ADDR[31:2], 2'b00};
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       addr_q;
    logic              discard_q;
    logic [31:0]       branch_tgt;
    logic [31:0]       issue_addr;
    logic              rsp_done;
    logic              keep;
    logic              drop;
    logic              pop;
    logic              can_issue;
    logic              issue;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_base;
    logic [CNT_W:0]    occupancy;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [31:0]       mem_data_q [FIFO_DEPTH];
    logic              mem_err_q  [FIFO_DEPTH];
    logic [31:0]       mem_pc_q   [FIFO_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Handshakes: a request transfers when instr_req_o & instr_gnt_i; a response is the single
    // rvalid cycle that follows; the FIFO head transfers when instr_valid_o & instr_ready_i.
    assign branch_tgt = {branch_addr_i[31:2], 2'b00};
    assign rsp_done   = (state_q == S_WAIT) && instr_rvalid_i;
    assign keep       = rsp_done && !discard_q && !branch_i;
    assign drop       = rsp_done && !keep;
    assign capture_o  = keep;
    assign pop        = instr_valid_o && instr_ready_i && !branch_i;

    // Space for the outstanding word is reserved at issue; a branch empties the buffer this cycle.
    assign count_base = branch_i ? '0 : count_q;
    assign occupancy  = {1'b0, count_base} + {{CNT_W{1'b0}}, keep};
    assign can_issue  = fetch_en_i && (occupancy < DEPTH_C);
    assign issue_addr = branch_i ? branch_tgt : fetch_pc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (can_issue) state_d = S_REQ;
            end
            S_REQ: begin
                if (instr_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rsp_done) begin
                    if (keep && instr_err_i) state_d = S_HALT;
                    else if (can_issue)      state_d = S_REQ;
                    else                     state_d = S_IDLE;
                end
            end
            S_HALT: begin
                if (branch_i) state_d = can_issue ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign issue = (state_d == S_REQ) && (state_q != S_REQ);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // fetch_pc_q always holds the next address to request; addr_q holds the one in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= BOOT_WORD;
            addr_q     <= BOOT_WORD;
            discard_q  <= 1'b0;
        end else begin
            if (issue) begin
                addr_q     <= issue_addr;
                fetch_pc_q <= issue_addr + 32'd4;
            end else if (branch_i) begin
                fetch_pc_q <= branch_tgt;
            end
            if (rsp_done)
                discard_q <= 1'b0;
            else if (branch_i && (state_q == S_REQ || state_q == S_WAIT))
                discard_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= 32'd0;
                mem_err_q[i]  <= 1'b0;
                mem_pc_q[i]   <= BOOT_WORD;
            end
        end else if (branch_i) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (keep) begin
                mem_data_q[wr_ptr_q] <= instr_rdata_i;
                mem_err_q[wr_ptr_q]  <= instr_err_i;
                mem_pc_q[wr_ptr_q]   <= addr_q;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(keep) - CNT_W'(pop);
        end
    end

    assign instr_req_o   = (state_q == S_REQ);
    assign instr_addr_o  = addr_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_rdata_o = mem_data_q[rd_ptr_q];
    assign instr_err_o   = mem_err_q[rd_ptr_q];
    assign instr_pc_o    = mem_pc_q[rd_ptr_q];
    assign fsm_state_o   = state_q;

`ifdef IF_FETCH_CTRL_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_o   <= 32'd0;
            perf_discard_o <= 16'd0;
        end else begin
            if (keep) perf_fetch_o   <= perf_fetch_o + 32'd1;
            if (drop) perf_discard_o <= perf_discard_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: linear steps, inputs driven #1 after posedge, outputs sampled at negedge.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_en_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'd0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = 32'd0;
    logic        instr_err_i = 1'b0;
    logic        capture_o;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic [1:0]  fsm_state_o;
`ifdef IF_FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_o;
    logic [15:0] perf_discard_o;
`endif

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    if_fetch_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .fetch_en_i(fetch_en_i),
        .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .capture_o(capture_o), .instr_valid_o(instr_valid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i),
        .fsm_state_o(fsm_state_o)
`ifdef IF_FETCH_CTRL_PERF_EN
        , .perf_fetch_o(perf_fetch_o), .perf_discard_o(perf_discard_o)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst_i = 1'b1; fetch_en_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        branch_i = 1'b0; instr_ready_i = 1'b0; instr_err_i = 1'b0;
    endtask

    // scoreboard compare
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset values
        step(); smp();
        chk("rst_req", {31'd0, instr_req_o}, 32'd0);
        chk("rst_addr", instr_addr_o, 32'h80);
        chk("rst_capture", {31'd0, capture_o}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_rdata", instr_rdata_o, 32'd0);
        chk("rst_err", {31'd0, instr_err_o}, 32'd0);
        chk("rst_pc", instr_pc_o, 32'h80);
        chk("rst_state", {30'd0, fsm_state_o}, 32'd0);

        // streaming: gnt tied high, rvalid one cycle after gnt, ready high
        step(); rst_i = 1'b0; fetch_en_i = 1'b1; instr_gnt_i = 1'b1; instr_ready_i = 1'b1;
        smp(); chk("s1_idle_req", {31'd0, instr_req_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); instr_rvalid_i = 1'b0;
            smp();
            chk("s1_req", {31'd0, instr_req_o}, 32'd1);
            chk("s1_addr", instr_addr_o, 32'h80 + 32'(4 * i));
            chk("s1_cap_idle", {31'd0, capture_o}, 32'd0);
            if (i > 0) begin
                e = exp_q.pop_front();
                chk("s1_valid", {31'd0, instr_valid_o}, 32'd1);
                chk("s1_pc", instr_pc_o, e[31:0]);
                chk("s1_data", instr_rdata_o, e[63:32]);
            end
            step(); instr_rvalid_i = 1'b1; instr_rdata_i = 32'hA000_0000 + 32'(i);
            exp_q.push_back({32'hA000_0000 + 32'(i), 32'h80 + 32'(4 * i)});
            smp();
            chk("s1_capture", {31'd0, capture_o}, 32'd1);
            chk("s1_req_wait", {31'd0, instr_req_o}, 32'd0);
        end
        step(); instr_rvalid_i = 1'b0;
        smp();
        e = exp_q.pop_front();
        chk("s1_req4", instr_addr_o, 32'h8C);
        chk("s1_pc_last", instr_pc_o, e[31:0]);
        chk("s1_data_last", instr_rdata_o, e[63:32]);

        // backpressure: ready low, depth 2 limits to two requests
        do_reset();
        step(); rst_i = 1'b0; fetch_en_i = 1'b1; instr_gnt_i = 1'b1;
        step(); smp(); chk("s2_addr0", instr_addr_o, 32'h80);
        step(); instr_rvalid_i = 1'b1; instr_rdata_i = 32'hB0; smp();
        step(); instr_rvalid_i = 1'b0; smp();
        chk("s2_req1", {31'd0, instr_req_o}, 32'd1);
        chk("s2_addr1", instr_addr_o, 32'h84);
        step(); instr_rvalid_i = 1'b1; instr_rdata_i = 32'hB1; smp();
        step(); instr_rvalid_i = 1'b0; smp();
        chk("s2_noreq_a", {31'd0, instr_req_o}, 32'd0);
        step(); smp();
        chk("s2_noreq_b", {31'd0, instr_req_o}, 32'd0);
        chk("s2_head_pc", instr_pc_o, 32'h80);
        step(); instr_ready_i = 1'b1; smp();
        chk("s2_noreq_c", {31'd0, instr_req_o}, 32'd0);
        step(); instr_ready_i = 1'b0; smp();
        chk("s2_head_pc2", instr_pc_o, 32'h84);
        chk("s2_head_data2", instr_rdata_o, 32'hB1);
        chk("s2_noreq_d", {31'd0, instr_req_o}, 32'd0);
        step(); smp();
        chk("s2_req_new", {31'd0, instr_req_o}, 32'd1);
        chk("s2_addr_new", instr_addr_o, 32'h88);

        // branch while in WAIT drops the pending response
        do_reset();
        step(); rst_i = 1'b0; fetch_en_i = 1'b1; instr_gnt_i = 1'b1; instr_ready_i = 1'b1;
        step(); smp();
        step(); branch_i = 1'b1; branch_addr_i = 32'h1003; smp();
        chk("s3_wait_state", {30'd0, fsm_state_o}, 32'd2);
        step(); branch_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD; smp();
        chk("s3_valid_flushed", {31'd0, instr_valid_o}, 32'd0);
        chk("s3_cap_dropped", {31'd0, capture_o}, 32'd0);
        step(); instr_rvalid_i = 1'b0; smp();
        chk("s3_req", {31'd0, instr_req_o}, 32'd1);
        chk("s3_addr", instr_addr_o, 32'h1000);
        chk("s3_empty", {31'd0, instr_valid_o}, 32'd0);
        step(); instr_rvalid_i = 1'b1; instr_rdata_i = 32'hC0; smp();
        chk("s3_capture", {31'd0, capture_o}, 32'd1);
        step(); instr_rvalid_i = 1'b0; smp();
        chk("s3_head_pc", instr_pc_o, 32'h1000);
        chk("s3_head_data", instr_rdata_o, 32'hC0);
        chk("s3_next_addr", instr_addr_o, 32'h1004);

        // error response halts fetch until a branch
        do_reset();
        step(); rst_i = 1'b0; fetch_en_i = 1'b1; instr_gnt_i = 1'b1;
        step(); smp();
        step(); instr_rvalid_i = 1'b1; instr_rdata_i = 32'hE0; smp();
        step(); instr_rvalid_i = 1'b0; smp();
        chk("s4_addr1", instr_addr_o, 32'h84);
        step(); instr_rvalid_i = 1'b1; instr_err_i = 1'b1; instr_rdata_i = 32'hE1; smp();
        chk("s4_capture_err", {31'd0, capture_o}, 32'd1);
        step(); instr_rvalid_i = 1'b0; instr_err_i = 1'b0; instr_ready_i = 1'b1; smp();
        chk("s4_halt_state", {30'd0, fsm_state_o}, 32'd3);
        chk("s4_noreq_a", {31'd0, instr_req_o}, 32'd0);
        chk("s4_head_pc0", instr_pc_o, 32'h80);
        step(); instr_ready_i = 1'b0; smp();
        chk("s4_head_pc", instr_pc_o, 32'h84);
        chk("s4_head_err", {31'd0, instr_err_o}, 32'd1);
        chk("s4_head_data", instr_rdata_o, 32'hE1);
        step(); smp();
        chk("s4_noreq_b", {31'd0, instr_req_o}, 32'd0);
        step(); branch_i = 1'b1; branch_addr_i = 32'h200; smp();
        chk("s4_noreq_c", {31'd0, instr_req_o}, 32'd0);
        step(); branch_i = 1'b0; smp();
        chk("s4_resume_req", {31'd0, instr_req_o}, 32'd1);
        chk("s4_resume_addr", instr_addr_o, 32'h200);
        chk("s4_flushed", {31'd0, instr_valid_o}, 32'd0);

        // PC wraps past the top of the address space
        do_reset();
        step(); rst_i = 1'b0; fetch_en_i = 1'b1; instr_gnt_i = 1'b1; instr_ready_i = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFC; smp();
        step(); branch_i = 1'b0; smp();
        chk("s5_req_top", {31'd0, instr_req_o}, 32'd1);
        chk("s5_addr_top", instr_addr_o, 32'hFFFF_FFFC);
        step(); instr_rvalid_i = 1'b1; instr_rdata_i = 32'hF0; smp();
        step(); instr_rvalid_i = 1'b0; smp();
        chk("s5_addr_wrap", instr_addr_o, 32'h0);
        chk("s5_head_pc", instr_pc_o, 32'hFFFF_FFFC);

        // reset during WAIT, late rvalid ignored
        do_reset();
        step(); rst_i = 1'b0; fetch_en_i = 1'b1; instr_gnt_i = 1'b1;
        step(); smp();
        step(); rst_i = 1'b1; smp();
        step(); rst_i = 1'b0; fetch_en_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h77; smp();
        chk("s6_cap_ignored", {31'd0, capture_o}, 32'd0);
        step(); instr_rvalid_i = 1'b0; fetch_en_i = 1'b1; smp();
        chk("s6_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("s6_noreq", {31'd0, instr_req_o}, 32'd0);
        step(); smp();
        chk("s6_req", {31'd0, instr_req_o}, 32'd1);
        chk("s6_addr", instr_addr_o, 32'h80);

        // branch in REQ without gnt: address holds, response dropped, then target
        do_reset();
        step(); rst_i = 1'b0; fetch_en_i = 1'b1; instr_gnt_i = 1'b0; instr_ready_i = 1'b1;
        step(); branch_i = 1'b1; branch_addr_i = 32'h400; smp();
        chk("s7_req_hold", {31'd0, instr_req_o}, 32'd1);
        step(); branch_i = 1'b0; instr_gnt_i = 1'b1; smp();
        chk("s7_addr_hold", instr_addr_o, 32'h80);
        step(); instr_rvalid_i = 1'b1; smp();
        chk("s7_cap_dropped", {31'd0, capture_o}, 32'd0);
        step(); instr_rvalid_i = 1'b0; smp();
        chk("s7_addr_tgt", instr_addr_o, 32'h400);
        chk("s7_empty", {31'd0, instr_valid_o}, 32'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Synchronous fetch sequencer for the instruction-side datapath. Issues instruction-memory requests over a req/gnt/rvalid handshake, tracks the fetch PC, and pulses a capture strobe for the fetch input register. Buffers returned words in a small FIFO for the decode side. Sits between the instruction memory port and the fetch input register / decode stage, and handles boot start, branch redirects and error halts.

## Interface
- `BOOT_ADDR`, default 32'h0000_0080: first fetch address after reset; bits [1:0] ignored (treated as 0).
- `FIFO_DEPTH`, default 2: response buffer entries; legal 2..8.
- `clk_i` in 1: single clock; all state updates on rising edge.
- `rst_i` in 1: reset is synchronous and active-high.
- `fetch_en_i` in 1: level; permits new requests.
- `branch_i` in 1: one-cycle redirect pulse.
- `branch_addr_i` in 32: redirect target; bits [1:0] forced to 0.
- `instr_req_o` out 1: memory request.
- `instr_addr_o` out 32: request address, word-aligned.
- `instr_gnt_i` in 1: request accepted this cycle.
- `instr_rvalid_i` in 1: response valid this cycle.
- `instr_rdata_i` in 32: response data.
- `instr_err_i` in 1: response error, qualified by rvalid.
- `capture_o` out 1: strobe to the fetch input register; high in the rvalid cycle of a kept response.
- `instr_valid_o` out 1: FIFO head valid.
- `instr_rdata_o` out 32: head data.
- `instr_err_o` out 1: head error flag.
- `instr_pc_o` out 32: head address.
- `instr_ready_i` in 1: decode pops head when valid & ready.

## Operation
- FSM states:
  - IDLE: no outstanding request.
  - REQ: `instr_req_o`=1, waiting for gnt.
  - WAIT: granted, waiting for rvalid.
  - HALT: error received.
- At most one request is outstanding.
- IDLE→REQ when `fetch_en_i` && !halt && (count + 0) < FIFO_DEPTH. Space is reserved at issue, so the FIFO never overflows.
- REQ→WAIT on gnt; fetch PC += 4 (mod 2^32, wraps 32'hFFFF_FFFC→0).
- While in REQ, `instr_addr_o` and `instr_req_o` hold stable until gnt, even across a branch.
- WAIT→REQ on rvalid when the issue condition holds that cycle; otherwise WAIT→IDLE.
- Kept response: push {rdata, err, pc}; `capture_o`=1 combinationally in that cycle.
- Response with err=1 is pushed, then the FSM enters HALT. No requests are issued in HALT until a branch.
- Branch:
  - Flush the FIFO and load the fetch PC with the target.
  - In WAIT, or in REQ (applied at gnt), set the discard flag. The next rvalid is dropped: no push, `capture_o`=0.
  - Branch exits HALT.
- Branch in the same cycle as rvalid: the response is discarded. Branch in the same cycle as a pop: the flush wins.
- Push and pop in the same cycle: count is unchanged.
- Reset in any state:
  - FSM → IDLE, PC → BOOT_ADDR, FIFO empty, discard cleared.
  - An rvalid arriving while in IDLE is ignored.

## Timing
- Reset values:
  - `instr_req_o`=0, `instr_addr_o`=BOOT_ADDR, `capture_o`=0.
  - `instr_valid_o`=0, `instr_rdata_o`=0, `instr_err_o`=0, `instr_pc_o`=BOOT_ADDR.
- `instr_req_o` and `instr_addr_o` are registered. With the issue condition true in cycle N, req is high in N+1.
- Gnt in the same cycle as req is legal. With rvalid in cycle M, `instr_valid_o` is high in M+1.
- Back-to-back with gnt in the req cycle and rvalid one cycle later: one word per 2 cycles.
- With an immediate re-issue on rvalid, next req is high in M+1.
- Branch in cycle B: `instr_valid_o`=0 in B+1. The first request to the target is in B+1 if IDLE, otherwise after the pending transaction completes.

## Configuration
- `IF_FETCH_CTRL_PERF_EN`:
  - Defined: adds outputs `perf_fetch_o`[31:0] and `perf_discard_o`[15:0], both wrapping. They count pushed responses and discarded responses. Cleared by reset.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, fetch_en=1, gnt tied 1, rvalid one cycle after gnt, ready=1 → addresses 0x80, 0x84, 0x88…; head pc/data match; `capture_o` pulses once per word.
- ready=0, FIFO_DEPTH=2 → exactly 2 requests issued, then req stays 0. Raising ready → one pop, one new request 0x88.
- Branch to 0x1003 while in WAIT → next rvalid dropped (`capture_o`=0), FIFO empty, following request address is 0x1000.
- rvalid with err=1 at 0x84 → head err=1 and pc=0x84; no further req; branch to 0x200 resumes at 0x200.
- PC 0xFFFF_FFFC granted → next request address 0x0000_0000.
- Assert rst_i during WAIT, then give a late rvalid → ignored; first request after release is to 0x80.
